ibus_dbus_arbiter: RTL and testbench
====================================

// Module: ibus_dbus_arbiter
// PURPOSE
//  Shares one single-ported slave bus (SRAM/crossbar port) between the core's data bus (M0) and
//  instruction bus (M1), so a single-port memory can serve both. Sits between rv_core's dbus/ibus
//  master ports and the memory. Transactions are never interleaved: one owner from grant to bdone.
//  A watchdog releases the bus if the slave never completes a transfer.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    32   data width
//  TIMEOUT   256  max cycles in a grant state before forced release; 0 disables the watchdog
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  m0_breq      in   1        dbus request (held until m0_bdone)
//  m0_ttype     in   ttype_e  dbus READ/WRITE
//  m0_tsize     in   tsize_e  dbus BYTE/HALF/WORD
//  m0_addr      in   ADDR_W   dbus address
//  m0_wdata     in   DATA_W   dbus write data
//  m0_rdata     out  DATA_W   dbus read data
//  m0_bdone     out  1        dbus transfer complete, 1-cycle pulse
//  m1_*         -    -        ibus, same set and meaning as m0_*
//  s_bstart     out  1        slave transfer active (level while granted and owner requests)
//  s_breq       out  1        equals s_bstart
//  s_ttype/s_tsize/s_addr/s_wdata  out  -  muxed from owner
//  s_rdata      in   DATA_W   slave read data
//  s_bdone      in   1        slave transfer complete
//  grant        out  2        one-hot owner {m1,m0}; 2'b00 when idle
//  bus_err      out  1        1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  - Reset: state IDLE, grant=00, s_bstart=0, m0/m1_bdone=0, bus_err=0, wdog=0, rr_last=M1.
//  - FSM states IDLE, GNT_M0, GNT_M1 (registered). Grant latency 1 cycle: breq seen in IDLE ->
//    GNT_x next cycle; s_bstart asserted from that cycle.
//  - IDLE: pick winner among requesters (policy below) -> GNT_x; none -> stay IDLE.
//  - GNT_x: s_* = master x signals; mx_bdone = s_bdone; other master's bdone = 0.
//    m0_rdata = m1_rdata = s_rdata (valid only with own bdone).
//  - On s_bdone in GNT_x: re-arbitrate same cycle; next state = winner of current requests
//    (owner's breq still counts) or IDLE -> back-to-back transfers with zero bubble.
//  - Owner drops breq before s_bdone (abort): s_bstart=0 that cycle, -> IDLE next cycle.
//  - s_bdone while IDLE: ignored, no master bdone.
//  - Watchdog: wdog counts cycles in GNT_x, cleared on any state change. If TIMEOUT!=0 and
//    wdog==TIMEOUT-1 with no s_bdone: pulse owner's bdone (rdata = s_rdata as-is), pulse bus_err,
//    -> IDLE. s_bdone in same cycle wins: normal completion, no bus_err.
//  - rst mid-transfer: immediate return to reset values next edge; outstanding slave op abandoned.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on contention, the master not granted most recently wins; rr_last
//    updates on every grant. Without it: fixed priority, M0 (dbus) always wins over M1 (ibus).
//  Single-requester behaviour identical in both builds.
// STRUCTURE
//  - arb_state_e {IDLE,GNT_M0,GNT_M1} and arb_master_e {M0,M1} go in bus_if_types_pkg alongside
//    ttype_e/tsize_e. Watchdog width = $clog2(TIMEOUT+1), local.
//  - No sub-module: FSM, winner select, output mux and watchdog fit one module.
// TESTING
//  1 Only M1 requests addr 0x100, slave bdone 2 cycles after s_bstart -> grant=10 next cycle,
//    m1_bdone one pulse, m0_bdone stays 0, s_addr=0x100 throughout.
//  2 M0 write 0x2000/0xCAFEF00D and M1 read 0x0 in same cycle from IDLE -> fixed: M0 first, then
//    M1 immediately after M0 bdone with no idle cycle; RR build, rr_last=M1: M0 first as well; then
//    repeat contention -> RR grants M1, fixed grants M0.
//  3 M1 held continuously (ibus style), M0 requests mid-M1 transfer -> M1 transfer not preempted;
//    grant switches to M0 on cycle after M1 bdone (fixed build).
//  4 TIMEOUT=8, slave never returns bdone -> after 8 grant cycles owner bdone=1 and bus_err=1 for
//    one cycle, state IDLE; bdone on cycle 8 exactly -> no bus_err.
//  5 rst=1 while GNT_M0 -> next cycle grant=00, s_bstart=0, all bdone=0; stray s_bdone in IDLE
//    produces no master bdone.
//  6 M0 drops breq before bdone -> s_bstart=0 same cycle, IDLE next, M1 grantable after.

Source files
------------

// File: rtl/bus_if_types_pkg.sv
// Purpose : shared bus transaction types plus the arbiter state/owner encodings.
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } arb_master_e;

endpackage

// File: rtl/ibus_dbus_arbiter.sv
// Purpose : shares one single-ported slave bus between dbus (M0) and ibus (M1), no interleaving.
// Latency : grant 1 cycle after breq from IDLE; back-to-back re-grant on s_bdone with no bubble.
// Backpressure: losing master waits with breq held; a watchdog force-releases a stuck slave.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_* / m1_*              master request (breq/ttype/tsize/addr/wdata) and response (rdata/bdone)
//   s_*                      slave side: muxed request from the owner, s_rdata/s_bdone back
//   grant                    one-hot owner {m1,m0}, 00 when idle
//   bus_err                  1-cycle pulse when the watchdog releases the bus
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on contention (default: M0 fixed priority).
module ibus_dbus_arbiter
  import bus_if_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_breq,
  input  ttype_e            m0_ttype,
  input  tsize_e            m0_tsize,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_bdone,
  input  logic              m1_breq,
  input  ttype_e            m1_ttype,
  input  tsize_e            m1_tsize,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_bdone,
  output logic              s_bstart,
  output logic              s_breq,
  output ttype_e            s_ttype,
  output tsize_e            s_tsize,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_bdone,
  output logic [1:0]        grant,
  output logic              bus_err
);

  // A disabled watchdog still gets a 1-bit counter so the declarations stay legal.
  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

  arb_state_e        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  arb_state_e        winner;
  logic              owner_req;
  logic              complete;
  logic              timeout;

`ifdef ARB_ROUND_ROBIN_EN
  arb_master_e       rr_last_q, rr_last_d;
`endif

  // Winner among the current requests; used both from IDLE and when a transfer completes.
  always_comb begin
    winner = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_breq && m1_breq) winner = (rr_last_q == M0) ? GNT_M1 : GNT_M0;
    else
`endif
    if (m0_breq)      winner = GNT_M0;
    else if (m1_breq) winner = GNT_M1;
  end

  always_comb begin
    owner_req = 1'b0;
    s_ttype   = READ;
    s_tsize   = BYTE;
    s_addr    = '0;
    s_wdata   = '0;
    case (state_q)
      GNT_M0: begin
        owner_req = m0_breq;
        s_ttype   = m0_ttype;
        s_tsize   = m0_tsize;
        s_addr    = m0_addr;
        s_wdata   = m0_wdata;
      end
      GNT_M1: begin
        owner_req = m1_breq;
        s_ttype   = m1_ttype;
        s_tsize   = m1_tsize;
        s_addr    = m1_addr;
        s_wdata   = m1_wdata;
      end
      default: ;
    endcase
  end

  // s_bdone always completes the owner's transfer, even if the owner let go of breq that cycle.
  // The watchdog only fires on a transfer the owner is still asking for.
  assign complete = (state_q != IDLE) && s_bdone;
  assign timeout  = (TIMEOUT != 0) && (state_q != IDLE) && owner_req && !s_bdone
                    && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = winner;
      default: begin
        if (complete)        state_d = winner;
        else if (!owner_req) state_d = IDLE;   // abort
        else if (timeout)    state_d = IDLE;
      end
    endcase
  end

  // Each new transfer starts a fresh count, including a re-grant to the same master.
  always_comb begin
    if ((state_d == IDLE) || (state_d != state_q) || complete) wdog_d = '0;
    else                                                        wdog_d = wdog_q + 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_last_d = rr_last_q;
    if ((state_d != IDLE) && ((state_q == IDLE) || complete))
      rr_last_d = (state_d == GNT_M0) ? M0 : M1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q <= M1;
`endif
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign grant    = {state_q == GNT_M1, state_q == GNT_M0};
  assign s_bstart = owner_req;
  assign s_breq   = owner_req;
  assign m0_bdone = (state_q == GNT_M0) && (complete || timeout);
  assign m1_bdone = (state_q == GNT_M1) && (complete || timeout);
  assign bus_err  = timeout;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// Purpose : self-checking bench for ibus_dbus_arbiter, directed scenarios then random traffic.
// Latency : checks each cycle against an owner/age reference model.
// Backpressure: bench masters hold breq until their bdone; slave completes at random.
module tb_ibus_dbus_arbiter;
  import bus_if_types_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_breq, m1_breq;
  ttype_e      m0_ttype, m1_ttype;
  tsize_e      m0_tsize, m1_tsize;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_bdone, m1_bdone;
  logic        s_bstart, s_breq, s_bdone, bus_err;
  ttype_e      s_ttype;
  tsize_e      s_tsize;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  ttype_e      f_tt[2];
  tsize_e      f_ts[2];
  logic [31:0] f_addr[2];
  logic [31:0] f_wd[2];

  assign m0_ttype = f_tt[0];   assign m1_ttype = f_tt[1];
  assign m0_tsize = f_ts[0];   assign m1_tsize = f_ts[1];
  assign m0_addr  = f_addr[0]; assign m1_addr  = f_addr[1];
  assign m0_wdata = f_wd[0];   assign m1_wdata = f_wd[1];

  ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_breq(m0_breq), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone),
    .m1_breq(m1_breq), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone),
    .s_bstart(s_bstart), .s_breq(s_breq), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .grant(grant), .bus_err(bus_err)
  );

  int   total = 0;
  int   bad   = 0;
  // Reference model: who owns the bus (-1 none), cycles spent owning it, last master granted.
  int   own, age, last;
  logic e_done[2];
  logic o_done0, o_done1, o_err, o_bstart;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic set_fields(input int k, input logic [31:0] a, input logic [31:0] d,
                            input ttype_e t, input tsize_e s);
    f_addr[k] = a; f_wd[k] = d; f_tt[k] = t; f_ts[k] = s;
  endtask

  task automatic rand_fields(input int k);
    set_fields(k, $urandom, $urandom, ttype_e'($urandom_range(0, 1)),
               tsize_e'($urandom_range(0, 2)));
  endtask

  // One clock cycle: drive, check every output against the model, clock, advance the model.
  task automatic step(input logic rs, input logic r0, input logic r1, input logic sd);
    logic       r[2];
    logic [1:0] eg;
    logic       ebst, hit, eerr;
    int         w;
    r[0] = r0; r[1] = r1;
    rst = rs; m0_breq = r0; m1_breq = r1; s_bdone = sd; s_rdata = $urandom;
    #4;
    eg   = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    ebst = (own >= 0) && r[own];
    hit  = (own >= 0) && (age == TO - 1);
    for (int k = 0; k < 2; k++) e_done[k] = (own == k) && (sd || (r[k] && hit));
    eerr = (own >= 0) && r[own] && !sd && hit;
    chk("grant", 64'(grant), 64'(eg));
    chk("s_bstart", 64'(s_bstart), 64'(ebst));
    chk("s_breq", 64'(s_breq), 64'(ebst));
    chk("m0_bdone", 64'(m0_bdone), 64'(e_done[0]));
    chk("m1_bdone", 64'(m1_bdone), 64'(e_done[1]));
    chk("bus_err", 64'(bus_err), 64'(eerr));
    if (own >= 0) begin
      chk("s_addr", 64'(s_addr), 64'(f_addr[own]));
      chk("s_wdata", 64'(s_wdata), 64'(f_wd[own]));
      chk("s_ttype", 64'(s_ttype), 64'(f_tt[own]));
      chk("s_tsize", 64'(s_tsize), 64'(f_ts[own]));
    end
    if (e_done[0]) chk("m0_rdata", 64'(m0_rdata), 64'(s_rdata));
    if (e_done[1]) chk("m1_rdata", 64'(m1_rdata), 64'(s_rdata));
    o_done0 = m0_bdone; o_done1 = m1_bdone; o_err = bus_err; o_bstart = s_bstart;
    @(posedge clk);
    #1;
    if (rs) begin
      own = -1; age = 0; last = 1;
    end else if (own < 0) begin
      w = winner(r0, r1);
      if (w >= 0) begin own = w; age = 0; last = w; end
    end else if (sd) begin
      w = winner(r0, r1);
      own = w; age = 0;
      if (w >= 0) last = w;
    end else if (!r[own] || hit) begin
      own = -1; age = 0;
    end else begin
      age++;
    end
  endtask

  int   act[2];
  logic rr[2];
  logic sdr;

  initial begin
    rst = 1'b1; m0_breq = 1'b0; m1_breq = 1'b0; s_bdone = 1'b0; s_rdata = '0;
    set_fields(0, 32'h0, 32'h0, READ, BYTE);
    set_fields(1, 32'h0, 32'h0, READ, BYTE);
    own = -1; age = 0; last = 1;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    step(0, 0, 0, 0);
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_bstart", 64'(o_bstart), 64'(1'b0));
    chk("rst_err", 64'(o_err), 64'(1'b0));

    // Only M1 requests 0x100; slave completes 2 cycles after s_bstart
    set_fields(1, 32'h100, 32'h0, READ, WORD);
    step(0, 0, 1, 0);
    chk("t1_grant", 64'(grant), 64'(2'b10));
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("t1_m1_done", 64'(o_done1), 64'(1'b1));
    chk("t1_m0_done", 64'(o_done0), 64'(1'b0));
    chk("t1_idle", 64'(grant), 64'(2'b00));

    // Contention from IDLE: M0 first, M1 with no bubble
    set_fields(0, 32'h2000, 32'hCAFEF00D, WRITE, WORD);
    set_fields(1, 32'h0, 32'h0, READ, WORD);
    step(0, 1, 1, 0);
    chk("t2_first", 64'(grant), 64'(2'b01));
    step(0, 0, 1, 1);
    chk("t2_m0_done", 64'(o_done0), 64'(1'b1));
    chk("t2_b2b", 64'(grant), 64'(2'b10));
    step(0, 0, 0, 1);
    // Repeat contention after M0 was last granted
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 1, 0);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_repeat", 64'(grant), 64'(2'b10));
`else
    chk("t2_repeat", 64'(grant), 64'(2'b01));
`endif
    step(0, 0, 0, 1);

    // M1 held, M0 arrives mid-transfer: no preemption
    set_fields(1, 32'h40, 32'h0, READ, WORD);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    chk("t3_hold_a", 64'(grant), 64'(2'b10));
    step(0, 1, 1, 0);
    chk("t3_hold_b", 64'(grant), 64'(2'b10));
    step(0, 1, 1, 1);
    chk("t3_switch", 64'(grant), 64'(2'b01));
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // Watchdog expiry after TO grant cycles
    step(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      step(0, 1, 0, 0);
      chk("t4_no_err_early", 64'(o_err), 64'(1'b0));
    end
    step(0, 1, 0, 0);
    chk("t4_err", 64'(o_err), 64'(1'b1));
    chk("t4_done", 64'(o_done0), 64'(1'b1));
    chk("t4_idle", 64'(grant), 64'(2'b00));
    // s_bdone on the last allowed cycle wins over the watchdog
    step(0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("t4_edge_err", 64'(o_err), 64'(1'b0));
    chk("t4_edge_done", 64'(o_done0), 64'(1'b1));

    // Reset mid-transfer, then a stray s_bdone while idle
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t5_grant", 64'(grant), 64'(2'b00));
    step(0, 0, 0, 1);
    chk("t5_stray0", 64'(o_done0), 64'(1'b0));
    chk("t5_stray1", 64'(o_done1), 64'(1'b0));

    // Abort by dropping breq
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_bstart", 64'(o_bstart), 64'(1'b0));
    chk("t6_idle", 64'(grant), 64'(2'b00));
    step(0, 0, 1, 0);
    chk("t6_m1", 64'(grant), 64'(2'b10));
    step(0, 0, 0, 1);

    // Random traffic
    act[0] = 0; act[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      sdr = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 2; k++) begin
        if (act[k] == 0) begin
          if ($urandom_range(0, 2) == 0) begin act[k] = 1; rand_fields(k); end
        end else if ($urandom_range(0, 39) == 0) begin
          act[k] = 0;
        end
        rr[k] = (act[k] != 0);
        if ((own == k) && sdr && ($urandom_range(0, 1) == 0)) rr[k] = 1'b0;
      end
      step(($urandom_range(0, 499) == 0), rr[0], rr[1], sdr);
      for (int k = 0; k < 2; k++) begin
        if (e_done[k]) begin
          act[k] = int'($urandom_range(0, 1));
          if (act[k] != 0) rand_fields(k);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
